// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder stepped LSB-first through a registered carry.
// Latency: DONE pulses WIDTH edges after the accepting START edge; START outside IDLE is dropped.

module FullAdder1bit_Structural (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic axb, ab, cx;

  xor g_x0 (axb, a, b);
  xor g_x1 (s, axb, cin);
  and g_a0 (ab, a, b);
  and g_a1 (cx, axb, cin);
  or  g_o0 (cout, ab, cx);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] opa, opb, psum;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            fa_s, fa_c;

  FullAdder1bit_Structural u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      COUT  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          BUSY <= 1'b0;
          if (START && !ABORT) begin
            opa   <= A;
            opb   <= B;
            carry <= CIN;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            psum  <= {fa_s, psum[WIDTH-1:1]};
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            // Last bit: publish the fully assembled sum, never a partial one
            if (cnt == CW'(WIDTH - 1)) begin
              SUM   <= {fa_s, psum[WIDTH-1:1]};
              COUT  <= fa_c;
              DONE  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl against an arithmetic A+B+CIN model.
module tb_serial_adder_ctrl;
  localparam int W = 8;
  localparam int LAT = W + 1;
  localparam int TMO = 40;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         ABORT = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         CIN = 1'b0;
  logic         BUSY, DONE, COUT;
  logic [W-1:0] SUM;

  int n_asrt = 0;
  int n_fail = 0;
  int lat;
  int held_sum = 0;
  int held_cout = 0;
  int pulses;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .ABORT (ABORT),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs/outputs are touched 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
    lat++;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    A = a; B = b; CIN = cin; START = 1'b1;
    lat = 0;
    step();
    START = 1'b0;
    A = W'($urandom); B = W'($urandom); CIN = 1'($urandom);
  endtask

  task automatic wait_done();
    while (!DONE && lat < TMO) step();
  endtask

  task automatic count_pulses(input int n);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (DONE) pulses++;
    end
  endtask

  // Model: result is plain (WIDTH+1)-bit arithmetic of the captured operands
  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin);
    int e;
    e = int'(a) + int'(b) + int'(cin);
    held_sum  = e % (1 << W);
    held_cout = e / (1 << W);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_sum"}, 32'(SUM), held_sum);
    chk({tag, "_cout"}, 32'(COUT), held_cout);
    chk({tag, "_busy_done"}, 32'(BUSY), 1);
    step();
    chk({tag, "_pulse"}, 32'(DONE), 0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    start_op(a, b, cin);
    wait_done();
    check_result(tag, a, b, cin);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           guard;

    // Reset state
    #2;
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_sum", 32'(SUM), 0);
    chk("rst_cout", 32'(COUT), 0);
    step();
    step();
    RST = 1'b0;
    step();

    // 1: basic add
    do_op("t1", 8'h5A, 8'h3C, 1'b0);
    chk("t1_sum_abs", 32'(SUM), 32'h96);

    // 3: START re-pulsed during RUN is ignored
    start_op(8'h5A, 8'h3C, 1'b0);
    chk("t3_busy_run", 32'(BUSY), 1);
    step();
    step();
    A = 8'h01; B = 8'h01; START = 1'b1;
    step();
    START = 1'b0;
    wait_done();
    check_result("t3", 8'h5A, 8'h3C, 1'b0);
    count_pulses(15);
    chk("t3_single_done", pulses, 0);

    // 2: full carry chains
    do_op("t2a", 8'hFF, 8'h01, 1'b0);
    chk("t2a_sum_abs", 32'(SUM), 32'h00);
    chk("t2a_cout_abs", 32'(COUT), 1);
    do_op("t2b", 8'hFF, 8'h00, 1'b1);
    chk("t2b_cout_abs", 32'(COUT), 1);

    // 4: ABORT on the 4th RUN cycle
    start_op(8'h10, 8'h20, 1'b0);
    step();
    step();
    step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    chk("t4_busy", 32'(BUSY), 0);
    chk("t4_done", 32'(DONE), 0);
    chk("t4_sum_held", 32'(SUM), held_sum);
    chk("t4_cout_held", 32'(COUT), held_cout);
    count_pulses(15);
    chk("t4_no_done", pulses, 0);
    START = 1'b1; ABORT = 1'b1;
    step();
    START = 1'b0; ABORT = 1'b0;
    chk("t4_start_abort_idle", 32'(BUSY), 0);
    count_pulses(15);
    chk("t4_sa_no_done", pulses, 0);
    chk("t4_sa_sum_held", 32'(SUM), held_sum);

    // 5: reset mid-RUN takes effect without a clock edge
    start_op(8'hC3, 8'h77, 1'b1);
    step();
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    chk("t5_busy", 32'(BUSY), 0);
    chk("t5_sum", 32'(SUM), 0);
    chk("t5_cout", 32'(COUT), 0);
    chk("t5_done", 32'(DONE), 0);
    step();
    RST = 1'b0;
    held_sum = 0;
    held_cout = 0;
    count_pulses(15);
    chk("t5_no_done", pulses, 0);
    do_op("t5_after", 8'hC3, 8'h77, 1'b1);

    // 6: random back-to-back operations, START as soon as BUSY drops
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      guard = 0;
      while (BUSY && guard < TMO) begin
        step();
        guard++;
      end
      start_op(ra, rb, rc);
      wait_done();
      check_result("t6", ra, rb, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
